memory_access_ctrl: RTL

Request-driven initiator for the synchronous-write / asynchronous-read bit memory. It accepts single-word read, write, toggle (read-modify-write) and clear-all commands over a valid/ready request channel. It drives the memory's write-enable, address and write-data ports, samples its combinational read data, and returns one response per command over a valid/ready response channel. It sits between sequencing logic and the memory instance, and shares the memory's clock.

---
 rtl/memory_access_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/memory_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_ctrl
// Purpose  : Valid/ready command front-end for a sync-write / async-read bit
//            memory: read, write, toggle (RMW) and clear-all, one response
//            per command. Optional readback check: MEMCTRL_READBACK_EN.
// Revision : 1.0  initial release
// ============================================================================
module memory_access_ctrl #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [1:0]        OP_READ   = 2'b00;
    localparam logic [1:0]        OP_WRITE  = 2'b01;
    localparam logic [1:0]        OP_TOGGLE = 2'b10;
    localparam logic [1:0]        OP_CLEAR  = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

`ifdef MEMCTRL_READBACK_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_CHECK = 3'd3,
        ST_RESP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_RESP  = 3'd4
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifdef MEMCTRL_READBACK_EN
    logic              err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
`ifdef MEMCTRL_READBACK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
`ifdef MEMCTRL_READBACK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Memory strobes decode straight from the state register so an
    // asynchronous reset removes mem_we_o without waiting for a clock edge.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
`ifdef MEMCTRL_READBACK_EN
        err_d       = err_q;
`endif
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = '0;
`ifdef MEMCTRL_READBACK_EN
                    err_d   = 1'b0;
`endif
                    state_d = (req_op_i == OP_CLEAR) ? ST_SWEEP : ST_EXEC;
                end
            end

            ST_EXEC: begin
                mem_addr_o = addr_q;
                case (op_q)
                    OP_WRITE: begin
                        mem_we_o    = 1'b1;
                        mem_wdata_o = wdata_q;
                        rsp_data_d  = wdata_q;
                    end
                    OP_TOGGLE: begin
                        mem_we_o    = 1'b1;
                        mem_wdata_o = ~mem_rdata_i;
                        rsp_data_d  = ~mem_rdata_i;
                    end
                    default: rsp_data_d = mem_rdata_i;
                endcase
`ifdef MEMCTRL_READBACK_EN
                state_d = (op_q == OP_READ) ? ST_RESP : ST_CHECK;
`else
                state_d = ST_RESP;
`endif
            end

            // The counter wraps back to 0 on the last address, which leaves
            // it ready for the readback sweep.
            ST_SWEEP: begin
                mem_we_o   = 1'b1;
                mem_addr_o = cnt_q;
                rsp_data_d = '0;
                cnt_d      = cnt_q + ADDR_ONE;
                if (cnt_q == ADDR_LAST) begin
`ifdef MEMCTRL_READBACK_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_RESP;
`endif
                end
            end

`ifdef MEMCTRL_READBACK_EN
            ST_CHECK: begin
                if (op_q == OP_CLEAR) begin
                    mem_addr_o = cnt_q;
                    if (mem_rdata_i != '0) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + ADDR_ONE;
                    if (cnt_q == ADDR_LAST) begin
                        state_d = ST_RESP;
                    end
                end else begin
                    mem_addr_o = addr_q;
                    err_d      = (mem_rdata_i != rsp_data_q);
                    state_d    = ST_RESP;
                end
            end
`endif

            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_data_o = rsp_data_q;
`ifdef MEMCTRL_READBACK_EN
    assign rsp_err_o  = err_q;
`else
    assign rsp_err_o  = 1'b0;
`endif

endmodule
`default_nettype wire
